// File: rtl/ff_reg_bank.sv
// ff_reg_bank: multi-mode (D/T/JK/shift) register with sync clear, enable, async preset value and change flag
module ff_reg_bank #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sclr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] k,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout,
  output logic             changed
);
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] q_next;
  assign sh   = {q, sin};
  assign qbar = ~q;
  assign sout = q[WIDTH-1];
  // next state: sclr beats en, en beats mode; sh drops the old msb so WIDTH=1 shifts in sin directly
  always_comb
    q_next = sclr          ? '0 :
             !en           ? q :
             mode == 2'b00 ? d :
             mode == 2'b01 ? q ^ d :
             mode == 2'b10 ? (d & ~q) | (~k & q) :
                             sh[WIDTH-1:0];
  // state and change flag, preset asynchronously to RESET_VAL
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      q       <= RESET_VAL;
      changed <= 1'b0;
    end else begin
      q       <= q_next;
      changed <= q_next != q;
    end
endmodule

// File: tb/tb_ff_reg_bank.sv
// tb_ff_reg_bank: directed and random checks of ff_reg_bank against a behavioural model
module tb_ff_reg_bank;
  localparam logic [3:0] RV = 4'b1010;
  logic       clk = 0, reset = 1, en = 0, sclr = 0, sin = 0;
  logic [1:0] mode = 0;
  logic [3:0] d = 0, k = 0, q, qbar;
  logic       sout, changed;
  logic [3:0] mq;
  logic       mch, live = 0;
  int         vectors = 0, miscompares = 0;

  ff_reg_bank #(.WIDTH(4), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .en(en), .sclr(sclr), .mode(mode), .d(d), .k(k),
    .sin(sin), .q(q), .qbar(qbar), .sout(sout), .changed(changed)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model_next(input logic [3:0] cur, input logic s, e,
                                            input logic [1:0] m, input logic [3:0] dd, kk,
                                            input logic si);
    logic [3:0] r;
    if (s) return 4'b0000;
    if (!e) return cur;
    case (m)
      2'd0: r = dd;
      2'd1: for (int i = 0; i < 4; i++) r[i] = dd[i] ? !cur[i] : cur[i];
      2'd2: for (int i = 0; i < 4; i++)
              case ({dd[i], kk[i]})
                2'b00: r[i] = cur[i];
                2'b10: r[i] = 1'b1;
                2'b01: r[i] = 1'b0;
                default: r[i] = !cur[i];
              endcase
      default: begin
        for (int i = 3; i > 0; i--) r[i] = cur[i-1];
        r[0] = si;
      end
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge reset)
    if (!reset) begin
      mq  <= RV;
      mch <= 1'b0;
    end else begin
      mq  <= model_next(mq, sclr, en, mode, d, k, sin);
      mch <= model_next(mq, sclr, en, mode, d, k, sin) != mq;
    end

  task automatic chk(input string name, input logic [3:0] got, exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (live) begin
      chk("model_q", q, mq);
      chk("model_qbar", qbar, ~mq);
      chk("model_sout", {3'b0, sout}, {3'b0, mq[3]});
      chk("model_changed", {3'b0, changed}, {3'b0, mch});
    end

  task automatic apply(input logic s, e, input logic [1:0] m, input logic [3:0] dd, kk,
                       input logic si);
    sclr = s; en = e; mode = m; d = dd; k = kk; sin = si;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3 reset = 0;
    #1;
    chk("rst_q", q, 4'b1010);
    chk("rst_qbar", qbar, 4'b0101);
    chk("rst_changed", {3'b0, changed}, 4'b0);
    live = 1;
    repeat (2) @(posedge clk);
    #1 chk("rst_hold_q", q, 4'b1010);
    @(negedge clk);
    #1 reset = 1;
    #1 chk("release_no_effect", q, 4'b1010);
    apply(0, 1, 2'd0, 4'b0110, 4'b0000, 0);
    chk("load_0110", q, 4'b0110);
    @(negedge clk);
    #2 reset = 0;
    #1;
    chk("midcycle_rst_q", q, 4'b1010);
    chk("midcycle_rst_qbar", qbar, 4'b0101);
    chk("midcycle_rst_changed", {3'b0, changed}, 4'b0);
    repeat (2) @(posedge clk);
    #1 chk("midcycle_rst_hold", q, 4'b1010);
    @(negedge clk);
    #1 reset = 1;
    apply(0, 1, 2'd0, 4'b0011, 4'b0000, 0);
    chk("d_q", q, 4'b0011);
    chk("d_changed", {3'b0, changed}, 4'b0001);
    repeat (2) apply(0, 0, 2'd0, 4'b1111, 4'b0000, 0);
    chk("en0_q", q, 4'b0011);
    chk("en0_changed", {3'b0, changed}, 4'b0);
    apply(0, 1, 2'd1, 4'b0101, 4'b0000, 0);
    chk("t1_q", q, 4'b0110);
    apply(0, 1, 2'd1, 4'b0101, 4'b0000, 0);
    chk("t2_q", q, 4'b0011);
    apply(0, 1, 2'd1, 4'b0000, 4'b0000, 0);
    chk("t0_q", q, 4'b0011);
    chk("t0_changed", {3'b0, changed}, 4'b0);
    apply(0, 1, 2'd1, 4'b0101, 4'b0000, 0);
    chk("t3_q", q, 4'b0110);
    apply(0, 1, 2'd2, 4'b1001, 4'b0110, 0);
    chk("jk_setclr", q, 4'b1001);
    apply(0, 1, 2'd2, 4'b1111, 4'b1111, 0);
    chk("jk_toggle", q, 4'b0110);
    apply(0, 1, 2'd2, 4'b0000, 4'b0100, 0);
    chk("jk_clr", q, 4'b0010);
    apply(0, 1, 2'd3, 4'b0000, 4'b0000, 1);
    chk("sh1_q", q, 4'b0101);
    chk("sh1_sout", {3'b0, sout}, 4'b0);
    apply(0, 1, 2'd3, 4'b0000, 4'b0000, 1);
    chk("sh2_q", q, 4'b1011);
    chk("sh2_sout", {3'b0, sout}, 4'b0001);
    apply(0, 1, 2'd3, 4'b0000, 4'b0000, 0);
    chk("sh3_q", q, 4'b0110);
    chk("sh3_sout", {3'b0, sout}, 4'b0);
    apply(0, 1, 2'd3, 4'b0000, 4'b0000, 1);
    chk("sh4_q", q, 4'b1101);
    chk("sh4_sout", {3'b0, sout}, 4'b0001);
    apply(1, 1, 2'd0, 4'b1111, 4'b0000, 0);
    chk("sclr_q", q, 4'b0000);
    chk("sclr_changed", {3'b0, changed}, 4'b0001);
    apply(1, 1, 2'd0, 4'b1111, 4'b0000, 0);
    chk("sclr0_q", q, 4'b0000);
    chk("sclr0_changed", {3'b0, changed}, 4'b0);
    reset = 0;
    #1 chk("rst_over_sclr", q, 4'b1010);
    @(negedge clk);
    #1 reset = 1;
    repeat (40)
      apply($urandom_range(0, 7) == 0, $urandom_range(0, 5) != 0, 2'($urandom_range(0, 3)),
            4'($urandom), 4'($urandom), 1'($urandom));
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
